// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: y0 = a + w*b, y1 = a - w*b over three register stages.
// Products are rounded or truncated, outputs can be scaled by 1/2, and results saturate.
module fft_butterfly_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROUND = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scale,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [2*WIDTH-1:0] w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y0,
  output logic [2*WIDTH-1:0] y1,
  output logic               ovf,
  output logic               ovf_sticky,
  input  logic               clr_ovf
);
  localparam int unsigned CW = 2 * WIDTH;
  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned SW = WIDTH + 3;

  localparam logic signed [PW-1:0] P_RND   = PW'((ROUND != 0) ? (64'd1 << (WIDTH - 2)) : 64'd0);
  localparam logic signed [SW-1:0] S_RND   = SW'((ROUND != 0) ? 1 : 0);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic                 en;
  logic                 v1, v2;
  logic                 sc1, sc2;
  logic [CW-1:0]        a1, b1, w1, a2;
  logic signed [RW-1:0] pr2, pi2;

  logic signed [PW-1:0] br, bi, wr, wi, pr_full, pi_full;
  logic signed [RW-1:0] pr_red, pi_red;

  logic signed [SW-1:0] ar, ai, pr3, pi3;
  logic [WIDTH:0]       r0, i0, r1, i1;
  logic                 any_sat;

  // Whole pipe advances together; a full output register stalls everything behind it.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a1  <= a;
      b1  <= b;
      w1  <= w;
      sc1 <= scale;
      a2  <= a1;
      sc2 <= sc1;
      pr2 <= pr_red;
      pi2 <= pi_red;
    end
  end

  // Full-precision complex product, then one reduction back to Q2.(WIDTH-1)-ish range.
  always_comb begin
    br      = PW'($signed(b1[CW-1:WIDTH]));
    bi      = PW'($signed(b1[WIDTH-1:0]));
    wr      = PW'($signed(w1[CW-1:WIDTH]));
    wi      = PW'($signed(w1[WIDTH-1:0]));
    pr_full = br * wr - bi * wi;
    pi_full = br * wi + bi * wr;
    pr_red  = RW'((pr_full + P_RND) >>> (WIDTH - 1));
    pi_red  = RW'((pi_full + P_RND) >>> (WIDTH - 1));
  end

  // Optional halving, then clamp to WIDTH bits; MSB of the result flags saturation.
  function automatic logic [WIDTH:0] trim(input logic signed [SW-1:0] s, input logic half);
    logic signed [SW-1:0] t;
    t = half ? ((s + S_RND) >>> 1) : s;
    if (t > SAT_MAX)      trim = {1'b1, SAT_MAX[WIDTH-1:0]};
    else if (t < SAT_MIN) trim = {1'b1, SAT_MIN[WIDTH-1:0]};
    else                  trim = {1'b0, t[WIDTH-1:0]};
  endfunction

  always_comb begin
    ar      = SW'($signed(a2[CW-1:WIDTH]));
    ai      = SW'($signed(a2[WIDTH-1:0]));
    pr3     = SW'(pr2);
    pi3     = SW'(pi2);
    r0      = trim(ar + pr3, sc2);
    i0      = trim(ai + pi3, sc2);
    r1      = trim(ar - pr3, sc2);
    i1      = trim(ai - pi3, sc2);
    any_sat = r0[WIDTH] | i0[WIDTH] | r1[WIDTH] | i1[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      y0        <= {r0[WIDTH-1:0], i0[WIDTH-1:0]};
      y1        <= {r1[WIDTH-1:0], i1[WIDTH-1:0]};
      ovf       <= v2 && any_sat;
    end
  end

  // A new saturation event takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
    end else if (en && v2 && any_sat) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
